// File: rtl/clock_pkg.sv
// Shared clock-setting types: sequencer state encoding, stage one-hot codes, default timeout.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SEC_LO = 3'd1,
    ST_SEC_HI = 3'd2,
    ST_MIN_LO = 3'd3,
    ST_MIN_HI = 3'd4,
    ST_HR_LO  = 3'd5,
    ST_HR_HI  = 3'd6
  } state_e;

  localparam logic [2:0] STAGE_SEC = 3'b001;
  localparam logic [2:0] STAGE_MIN = 3'b010;
  localparam logic [2:0] STAGE_HR  = 3'b100;

  localparam int TIMEOUT_S_DEF = 10;

  function automatic state_e next_state(input state_e s);
    case (s)
      ST_RUN:    return ST_SEC_LO;
      ST_SEC_LO: return ST_SEC_HI;
      ST_SEC_HI: return ST_MIN_LO;
      ST_MIN_LO: return ST_MIN_HI;
      ST_MIN_HI: return ST_HR_LO;
      ST_HR_LO:  return ST_HR_HI;
      default:   return ST_RUN;
    endcase
  endfunction

  function automatic logic [2:0] stage_of(input state_e s);
    case (s)
      ST_SEC_LO, ST_SEC_HI: return STAGE_SEC;
      ST_MIN_LO, ST_MIN_HI: return STAGE_MIN;
      ST_HR_LO,  ST_HR_HI:  return STAGE_HR;
      default:              return 3'b000;
    endcase
  endfunction

  function automatic logic is_hi(input state_e s);
    return (s == ST_SEC_HI) || (s == ST_MIN_HI) || (s == ST_HR_HI);
  endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a synchronous button level; prev resets high so a
// button held through reset yields no edge. Edge output is combinational.
module edge_det (
  input  logic clks,
  input  logic sclr_n,
  input  logic btn,
  output logic rise
);

  logic prev_q, prev_d;

  always_comb prev_d = btn;

  always_ff @(posedge clks) begin
    if (!sclr_n) prev_q <= 1'b1;
    else         prev_q <= prev_d;
  end

  assign rise = btn & ~prev_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Clock mode/setting sequencer: buttons -> registered set-mode selects and strobes, 1-cycle latency.
// TIME_SET_TIMEOUT_EN compiles in the automatic return to RUN after TIMEOUT_S idle ticks.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = TIMEOUT_S_DEF
) (
  input  logic       clks,
  input  logic       sclr_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_clr,
  output logic       run,
  output logic [2:0] set_en,
  output logic       selw,
  output logic       inc_pulse,
  output logic       clr_pulse,
  output logic       blank
);

  if (TIMEOUT_S < 1 || TIMEOUT_S > 255) begin : g_bad_timeout
    $error("TIMEOUT_S must be in 1..255");
  end

  logic mode_e, inc_e, clr_e;
  logic timeout;

  edge_det u_mode (.clks(clks), .sclr_n(sclr_n), .btn(btn_mode), .rise(mode_e));
  edge_det u_inc  (.clks(clks), .sclr_n(sclr_n), .btn(btn_inc),  .rise(inc_e));
  edge_det u_clr  (.clks(clks), .sclr_n(sclr_n), .btn(btn_clr),  .rise(clr_e));

  state_e     state_q, state_d;
  logic       run_q, run_d;
  logic [2:0] set_en_q, set_en_d;
  logic       selw_q, selw_d;
  logic       inc_q, inc_d;
  logic       clr_q, clr_d;
  logic       blink_q, blink_d;

`ifdef TIME_SET_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_S);
  logic [7:0] cnt_q, cnt_d;
  logic       any_edge;

  assign any_edge = mode_e | inc_e | clr_e;

  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (any_edge || state_q == ST_RUN) begin
      cnt_d = '0;
    end else if (tick_1hz) begin
      if (cnt_q + 8'd1 == TO_LIM) begin
        timeout = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clks) begin
    if (!sclr_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (mode_e)       state_d = next_state(state_q);
    else if (timeout) state_d = ST_RUN;

    // Blink restarts from "visible" whenever the selected digit moves.
    blink_d = blink_q;
    if (state_d == ST_RUN || state_d != state_q) blink_d = 1'b0;
    else if (tick_1hz)                           blink_d = ~blink_q;

    run_d    = (state_d == ST_RUN);
    set_en_d = stage_of(state_d);
    selw_d   = is_hi(state_d);
    inc_d    = inc_e & ~mode_e & (state_q != ST_RUN);
    clr_d    = clr_e;
  end

  always_ff @(posedge clks) begin
    if (!sclr_n) begin
      state_q  <= ST_RUN;
      run_q    <= 1'b1;
      set_en_q <= 3'b000;
      selw_q   <= 1'b0;
      inc_q    <= 1'b0;
      clr_q    <= 1'b0;
      blink_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      set_en_q <= set_en_d;
      selw_q   <= selw_d;
      inc_q    <= inc_d;
      clr_q    <= clr_d;
      blink_q  <= blink_d;
    end
  end

  assign run       = run_q;
  assign set_en    = set_en_q;
  assign selw      = selw_q;
  assign inc_pulse = inc_q;
  assign clr_pulse = clr_q;
  assign blank     = blink_q & ~run_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_time_set_ctrl;

  logic       clks = 1'b0;
  logic       sclr_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_clr = 1'b0;
  logic       run;
  logic [2:0] set_en;
  logic       selw, inc_pulse, clr_pulse, blank;

  int n_cmp = 0;
  int n_fail = 0;

  time_set_ctrl #(.TIMEOUT_S(3)) dut (
    .clks(clks), .sclr_n(sclr_n), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_clr(btn_clr),
    .run(run), .set_en(set_en), .selw(selw),
    .inc_pulse(inc_pulse), .clr_pulse(clr_pulse), .blank(blank)
  );

  always #5 clks = ~clks;

  // Observed word: {run, set_en[2:0], selw, inc_pulse, clr_pulse, blank}
  logic [7:0] obs;
  assign obs = {run, set_en, selw, inc_pulse, clr_pulse, blank};

  typedef struct packed {
    logic       rst_n;
    logic       mode;
    logic       inc;
    logic       clr;
    logic       tick;
    logic [7:0] exp;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic m, input logic i,
                              input logic c, input logic t, input logic [7:0] e);
    vec_t v;
    v.rst_n = r; v.mode = m; v.inc = i; v.clr = c; v.tick = t; v.exp = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clks);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc();
    btn_mode = 1'b0; cyc();
  endtask

  task automatic tick_pulse();
    tick_1hz = 1'b1; cyc();
    tick_1hz = 1'b0; cyc();
  endtask

  initial begin
    int cnt;
    //                 rst m  i  c  t   run set selw inc clr blank
    vecs[0]  = mk(0, 1, 0, 0, 0, 8'b1_000_0_000);
    vecs[1]  = mk(1, 1, 0, 0, 0, 8'b1_000_0_000);
    vecs[2]  = mk(1, 0, 0, 0, 0, 8'b1_000_0_000);
    vecs[3]  = mk(1, 0, 0, 0, 1, 8'b1_000_0_000);
    vecs[4]  = mk(1, 1, 0, 0, 0, 8'b0_001_0_000);
    vecs[5]  = mk(1, 0, 0, 0, 1, 8'b0_001_0_001);
    vecs[6]  = mk(1, 0, 1, 0, 0, 8'b0_001_0_101);
    vecs[7]  = mk(1, 0, 1, 0, 0, 8'b0_001_0_001);
    vecs[8]  = mk(1, 0, 0, 0, 1, 8'b0_001_0_000);
    vecs[9]  = mk(1, 1, 1, 0, 0, 8'b0_001_1_000);
    vecs[10] = mk(1, 0, 0, 0, 0, 8'b0_001_1_000);
    vecs[11] = mk(1, 1, 0, 0, 0, 8'b0_010_0_000);
    vecs[12] = mk(1, 0, 0, 0, 1, 8'b0_010_0_001);
    vecs[13] = mk(1, 1, 0, 1, 0, 8'b0_010_1_010);
    vecs[14] = mk(1, 0, 0, 1, 0, 8'b0_010_1_000);
    vecs[15] = mk(1, 1, 0, 0, 0, 8'b0_100_0_000);
    vecs[16] = mk(1, 0, 0, 0, 0, 8'b0_100_0_000);
    vecs[17] = mk(1, 1, 0, 0, 0, 8'b0_100_1_000);
    vecs[18] = mk(1, 0, 0, 0, 1, 8'b0_100_1_001);
    vecs[19] = mk(1, 1, 0, 0, 1, 8'b1_000_0_000);
    vecs[20] = mk(1, 0, 1, 0, 0, 8'b1_000_0_000);
    vecs[21] = mk(1, 0, 0, 1, 0, 8'b1_000_0_010);
    vecs[22] = mk(1, 0, 0, 0, 0, 8'b1_000_0_000);

    #2;
    for (int k = 0; k < NVEC; k++) begin
      sclr_n   = vecs[k].rst_n;
      btn_mode = vecs[k].mode;
      btn_inc  = vecs[k].inc;
      btn_clr  = vecs[k].clr;
      tick_1hz = vecs[k].tick;
      cyc();
      check($sformatf("vec[%0d]", k), obs, vecs[k].exp);
    end
    btn_mode = 0; btn_inc = 0; btn_clr = 0; tick_1hz = 0;

    // Reset then idle through 20 ticks.
    sclr_n = 1'b0; cyc();
    sclr_n = 1'b1; cyc();
    for (int k = 0; k < 20; k++) begin
      tick_1hz = 1'b1; cyc();
      check($sformatf("idle_tick%0d", k), obs, 8'b1_000_0_000);
      tick_1hz = 1'b0; cyc();
    end

    // Mode walk: 1st press SEC_LO, 4th MIN_HI, 7th back to RUN.
    press_mode();
    check("walk_p1", obs, 8'b0_001_0_000);
    press_mode(); press_mode(); press_mode();
    check("walk_p4", obs, 8'b0_010_1_000);
    press_mode(); press_mode(); press_mode();
    check("walk_p7", obs, 8'b1_000_0_000);

    // Reset in MIN_LO with blank high, mode held across reset.
    press_mode(); press_mode(); press_mode();
    tick_pulse();
    check("minlo_blank", obs, 8'b0_010_0_001);
    btn_mode = 1'b1; sclr_n = 1'b0; cyc();
    check("rst_mid", obs, 8'b1_000_0_000);
    sclr_n = 1'b1; cyc();
    check("rst_held_mode", obs, 8'b1_000_0_000);
    btn_mode = 1'b0; cyc();
    btn_mode = 1'b1; cyc();
    check("after_rst_press", obs, 8'b0_001_0_000);
    btn_mode = 1'b0; cyc();

    // Long increment hold in SEC_HI gives one pulse.
    press_mode();
    check("sechi", obs, 8'b0_001_1_000);
    cnt = 0;
    btn_inc = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (inc_pulse === 1'b1) cnt++;
    end
    btn_inc = 1'b0; cyc();
    check("inc_hold_set", 8'(cnt), 8'd1);
    for (int k = 0; k < 5; k++) press_mode();
    check("back_run", obs, 8'b1_000_0_000);
    cnt = 0;
    btn_inc = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (inc_pulse === 1'b1) cnt++;
    end
    btn_inc = 1'b0; cyc();
    check("inc_hold_run", 8'(cnt), 8'd0);

    // Timeout behaviour from HR_LO.
    for (int k = 0; k < 5; k++) press_mode();
    check("hrlo", obs, 8'b0_100_0_000);
`ifdef TIME_SET_TIMEOUT_EN
    tick_pulse(); check("to_t1", obs, 8'b0_100_0_001);
    tick_pulse(); check("to_t2", obs, 8'b0_100_0_000);
    tick_pulse(); check("to_t3", obs, 8'b1_000_0_000);
    for (int k = 0; k < 5; k++) press_mode();
    tick_pulse(); check("rs_t1", obs, 8'b0_100_0_001);
    tick_pulse(); check("rs_t2", obs, 8'b0_100_0_000);
    btn_inc = 1'b1; cyc();
    check("rs_inc", obs, 8'b0_100_0_100);
    btn_inc = 1'b0; cyc();
    tick_pulse(); check("rs_t3", obs, 8'b0_100_0_001);
    tick_pulse(); check("rs_t4", obs, 8'b0_100_0_000);
    tick_pulse(); check("rs_t5", obs, 8'b1_000_0_000);
`else
    for (int k = 1; k <= 10; k++) begin
      tick_pulse();
      check($sformatf("noto_t%0d", k), obs, {7'b0_100_0_00, 1'(k % 2)});
    end
    press_mode(); press_mode();
    check("noto_run", obs, 8'b1_000_0_000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
